// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, byte type, GF(2^8) helpers and the
// MixColumns stage FSM encoding.
package aes_pkg;

  localparam int STATE_DIM = 4;

  typedef logic [7:0] aes_byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    HOLD = 2'd2
  } mix_state_e;

  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Shift-and-add multiply; only instantiated with constant coefficients.
  function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
    aes_byte_t acc;
    aes_byte_t p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_mixcolumn_word.sv
// Combinational single-column (4-byte) MixColumns mixer.
// AES_INV_MIXCOLUMNS_EN adds the inv_i select for InvMixColumns.
module aes_mixcolumn_word
  import aes_pkg::*;
(
  input  aes_byte_t [STATE_DIM-1:0] col_i,
`ifdef AES_INV_MIXCOLUMNS_EN
  input  logic                      inv_i,
`endif
  output aes_byte_t [STATE_DIM-1:0] col_o
);

  for (genvar r = 0; r < STATE_DIM; r++) begin : g_row
    localparam int R1 = (r + 1) % STATE_DIM;
    localparam int R2 = (r + 2) % STATE_DIM;
    localparam int R3 = (r + 3) % STATE_DIM;

    aes_byte_t fwd;
    assign fwd = xtime(col_i[r]) ^ xtime(col_i[R1]) ^ col_i[R1] ^ col_i[R2] ^ col_i[R3];

`ifdef AES_INV_MIXCOLUMNS_EN
    aes_byte_t inv;
    assign inv = gf_mul(col_i[r],  8'h0E) ^ gf_mul(col_i[R1], 8'h0B) ^
                 gf_mul(col_i[R2], 8'h0D) ^ gf_mul(col_i[R3], 8'h09);
    assign col_o[r] = inv_i ? inv : fwd;
`else
    assign col_o[r] = fwd;
`endif
  end

endmodule

// File: rtl/aes_mixcolumns.sv
// Iterative AES MixColumns stage: one shared column mixer, one column per cycle.
// AES_INV_MIXCOLUMNS_EN adds the decrypt port and the InvMixColumns path.
module aes_mixcolumns
  import aes_pkg::*;
#(
  parameter int STATE_ARRAY_DIMENSION = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic       next_is_ready,
  input  logic       last_round,
`ifdef AES_INV_MIXCOLUMNS_EN
  input  logic       decrypt,
`endif
  input  logic [STATE_ARRAY_DIMENSION-1:0][STATE_ARRAY_DIMENSION-1:0][7:0] state_array,
  output logic [STATE_ARRAY_DIMENSION-1:0][STATE_ARRAY_DIMENSION-1:0][7:0] state_array_out,
  output logic       ready,
  output logic       valid_out,
  output mix_state_e dbg_state
);

  if (STATE_ARRAY_DIMENSION != STATE_DIM) begin : g_bad_dim
    $error("aes_mixcolumns: STATE_ARRAY_DIMENSION must be 4");
  end

  // Handshake: a block is taken on any edge where valid && ready. ready is high
  // in IDLE, or in HOLD when downstream takes the current result that same edge.
  // valid_out is high only in HOLD, where the result is held stable.
  mix_state_e state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [STATE_DIM-1:0][STATE_DIM-1:0][7:0] work_q, work_d;
  aes_byte_t [STATE_DIM-1:0] mix_in, mix_out;
  logic accept;
  logic inv_sel;

`ifdef AES_INV_MIXCOLUMNS_EN
  logic inv_q, inv_d;
  assign inv_sel = inv_q;
`else
  assign inv_sel = 1'b0;
`endif

  assign ready     = !reset && (state_q == IDLE || (state_q == HOLD && next_is_ready));
  assign accept    = valid && ready;
  assign valid_out = (state_q == HOLD);
  assign dbg_state = state_q;
  assign state_array_out = work_q;

  always_comb begin
    mix_in = '0;
    for (int r = 0; r < STATE_DIM; r++) mix_in[r] = work_q[r][col_q];
  end

  aes_mixcolumn_word u_word (
    .col_i (mix_in),
`ifdef AES_INV_MIXCOLUMNS_EN
    .inv_i (inv_sel),
`endif
    .col_o (mix_out)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
`ifdef AES_INV_MIXCOLUMNS_EN
    inv_d   = inv_q;
`endif
    unique case (state_q)
      IDLE: ;
      MIX: begin
        for (int r = 0; r < STATE_DIM; r++) work_d[r][col_q] = mix_out[r];
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) state_d = HOLD;
      end
      HOLD: if (next_is_ready && !valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Accept overrides the per-state update, covering back-to-back from HOLD.
    if (accept) begin
      work_d  = state_array;
      col_d   = 2'd0;
      state_d = last_round ? HOLD : MIX;
`ifdef AES_INV_MIXCOLUMNS_EN
      inv_d   = decrypt;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      work_q  <= '0;
`ifdef AES_INV_MIXCOLUMNS_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
`ifdef AES_INV_MIXCOLUMNS_EN
      inv_q   <= inv_d;
`endif
    end
  end

  logic unused_inv;
  assign unused_inv = inv_sel;

endmodule

// File: tb/tb_aes_mixcolumns.sv
// Directed bench for aes_mixcolumns with an expected-result queue.
// Define AES_INV_MIXCOLUMNS_EN to also exercise the inverse path.
module tb_aes_mixcolumns;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic valid = 1'b0;
  logic next_is_ready = 1'b0;
  logic last_round = 1'b0;
  logic decrypt = 1'b0;
  logic [3:0][3:0][7:0] state_array = '0;
  logic [3:0][3:0][7:0] state_array_out;
  logic ready, valid_out;
  mix_state_e dbg_state;

  logic [127:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit toggle_en = 1'b0;

  logic [127:0] t1, t1o, t5, t5o;
  int n;

  always #5 clk = ~clk;

  aes_mixcolumns dut (
    .clk             (clk),
    .reset           (reset),
    .valid           (valid),
    .next_is_ready   (next_is_ready),
    .last_round      (last_round),
`ifdef AES_INV_MIXCOLUMNS_EN
    .decrypt         (decrypt),
`endif
    .state_array     (state_array),
    .state_array_out (state_array_out),
    .ready           (ready),
    .valid_out       (valid_out),
    .dbg_state       (dbg_state)
  );

  // Columns given as {row0,row1,row2,row3}; state is indexed [row][column].
  function automatic logic [127:0] mk(input logic [31:0] c0, c1, c2, c3);
    logic [3:0][3:0][7:0] s;
    logic [3:0][31:0] cols;
    cols = {c3, c2, c1, c0};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = cols[c][31-8*r -: 8];
    return s;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept_block(input logic [127:0] data, input logic lr, input logic dec,
                              input logic [127:0] exp);
    state_array = data;
    last_round  = lr;
    decrypt     = dec;
    valid       = 1'b1;
    #1;
    check("accept_ready", ready, 1);
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Edges counted after the accept edge until valid_out is seen.
  task automatic wait_out(output int cnt);
    cnt = 0;
    while (!valid_out && cnt < 20) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
      if (toggle_en) valid = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic collect(input string tag);
    logic [127:0] exp;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check(tag, state_array_out, exp);
  endtask

  task automatic release_to_idle();
    next_is_ready = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    next_is_ready = 1'b0;
    #1;
    check("idle_valid_out", valid_out, 0);
    check("idle_ready", ready, 1);
  endtask

  initial begin
    t1  = mk(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h2d26314c);
    t1o = mk(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h4d7ebdf8);
    t5  = mk(32'hc6c6c6c6, 32'hd4d4d4d5, 32'h01010101, 32'h2d26314c);
    t5o = mk(32'hc6c6c6c6, 32'hd5d5d7d6, 32'h01010101, 32'h4d7ebdf8);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready_low", ready, 0);
    check("rst_out_zero", state_array_out, 0);
    check("rst_valid_out", valid_out, 0);
    check("rst_state_idle", dbg_state, IDLE);
    reset = 1'b0;
    #1;
    check("post_rst_ready", ready, 1);

    // Forward mix
    accept_block(t1, 1'b0, 1'b0, t1o);
    check("fwd_valid_low_after_accept", valid_out, 0);
    wait_out(n);
    check("fwd_latency", n, 4);
    collect("fwd_data");
    check("hold_ready_low", ready, 0);
    release_to_idle();

    // Last-round bypass, then 10 cycles of backpressure
    accept_block(t1, 1'b1, 1'b0, t1);
    wait_out(n);
    check("bypass_latency", n, 0);
    collect("bypass_data");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_data_stable", state_array_out, t1);
      check("bp_valid_ready", {valid_out, ready}, 2'b10);
    end

    // Back-to-back accept on the transfer edge; valid toggled during MIX
    next_is_ready = 1'b1;
    accept_block(t5, 1'b0, 1'b0, t5o);
    next_is_ready = 1'b0;
    check("b2b_valid_low", valid_out, 0);
    toggle_en = 1'b1;
    wait_out(n);
    toggle_en = 1'b0;
    valid = 1'b0;
    check("ignore_valid_latency", n, 4);
    collect("mix_c6_d4_data");
    release_to_idle();

    // Reset in the middle of MIX at col=2
    accept_block(t1, 1'b0, 1'b0, t1o);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check("midmix_rst_ready_low", ready, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("midmix_rst_out_zero", state_array_out, 0);
    check("midmix_rst_valid_out", valid_out, 0);
    check("midmix_rst_ready", ready, 1);
    accept_block(t1, 1'b0, 1'b0, t1o);
    wait_out(n);
    check("fresh_latency", n, 4);
    collect("fresh_data");
    release_to_idle();

`ifdef AES_INV_MIXCOLUMNS_EN
    // Inverse mix recovers the forward inputs; bypass still applies
    accept_block(t1o, 1'b0, 1'b1, t1);
    wait_out(n);
    check("inv_latency", n, 4);
    collect("inv_data");
    release_to_idle();
    accept_block(t1o, 1'b1, 1'b1, t1o);
    wait_out(n);
    check("inv_bypass_latency", n, 0);
    collect("inv_bypass_data");
    release_to_idle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
